// File: rtl/hub75e_pkg.sv
// Purpose: shared constants, types and helpers for the HUB75E receiver.
// Contents: geometry/PWM constants, rgb15_t, fb_word_t, rx_state_e,
//           sat_inc (saturating 5-bit increment), pack_fb (frame word packing).
package hub75e_pkg;

  localparam int unsigned ROW_BITS = 5;
  localparam int unsigned ROW_CNT  = 1 << ROW_BITS;
  localparam int unsigned COL_BITS = 6;
  localparam int unsigned COL_CNT  = 1 << COL_BITS;
  localparam int unsigned PWM_BITS = 5;
  localparam int unsigned SUB_CNT  = 1 << PWM_BITS;

  // Six colour channels per column: {R1,G1,B1,R2,G2,B2}
  localparam int unsigned NUM_CH = 6;
  localparam int unsigned CH_W   = PWM_BITS;
  localparam int unsigned ACC_W  = NUM_CH * CH_W;
  localparam int unsigned FB_W   = 32;

  typedef struct packed {
    logic [4:0] r;
    logic [4:0] g;
    logic [4:0] b;
  } rgb15_t;

  typedef logic [FB_W-1:0] fb_word_t;

  typedef enum logic [1:0] {IDLE, RD, WR} rx_state_e;

  // Accumulator add of one subframe bit, clamped at full scale
  function automatic logic [CH_W-1:0] sat_inc(input logic [CH_W-1:0] a, input logic b);
    return (a == '1) ? a : a + CH_W'(b);
  endfunction

  // Frame-RAM word: {0,R1,G1,B1, 0,R2,G2,B2}
  function automatic fb_word_t pack_fb(input rgb15_t top, input rgb15_t bot);
    return {1'b0, top, 1'b0, bot};
  endfunction

endpackage

// File: rtl/hub75e_acc_ram.sv
// Purpose: simple dual-port accumulator RAM, one write port and one read port
//          with a registered (1-cycle) read.
// Ports: CLK_IN clock; i_we/i_waddr/i_wdata write port;
//        i_raddr read address; o_rdata read data (valid the cycle after i_raddr).
module hub75e_acc_ram #(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned DATA_W = 30
) (
  input  logic              CLK_IN,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Contents are don't-care after reset; the first subframe overwrites them
  always_ff @(posedge CLK_IN) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/hub75e_rx.sv
// Purpose: HUB75E panel receiver. Samples the driver's serial lines, rebuilds
//          each pixel's PWM value by counting "on" subframes, and writes the
//          finished image into a frame RAM.
// Ports: CLK_IN/resetn (sync, active-low); hub_* panel inputs (async);
//        fb_we/fb_waddr/fb_wdata frame-RAM write; frame_done end-of-image pulse;
//        err_len/err_ovr/oe_bad sticky protocol flags.
module hub75e_rx
  import hub75e_pkg::*;
#(
  parameter int unsigned ROW_AW = ROW_BITS,
  parameter int unsigned COL_AW = COL_BITS
) (
  input  logic                     CLK_IN,
  input  logic                     resetn,
  input  logic                     hub_R1,
  input  logic                     hub_G1,
  input  logic                     hub_B1,
  input  logic                     hub_R2,
  input  logic                     hub_G2,
  input  logic                     hub_B2,
  input  logic                     hub_A,
  input  logic                     hub_B,
  input  logic                     hub_C,
  input  logic                     hub_D,
  input  logic                     hub_E,
  input  logic                     hub_CK,
  input  logic                     hub_ST,
  input  logic                     hub_OE,
  output logic                     fb_we,
  output logic [ROW_AW+COL_AW-1:0] fb_waddr,
  output fb_word_t                 fb_wdata,
  output logic                     frame_done,
  output logic                     err_len,
  output logic                     err_ovr,
  output logic                     oe_bad
);

  localparam int unsigned COLS   = 1 << COL_AW;
  localparam int unsigned ADDR_W = ROW_AW + COL_AW;
  localparam int unsigned CNT_W  = COL_AW + 1;
  localparam int unsigned IN_W   = 14;
  localparam int unsigned LINE_W = NUM_CH;

  // Input bundle: [13:8] colour {R1,G1,B1,R2,G2,B2}, [7:3] {E,D,C,B,A}, [2] CK, [1] ST, [0] OE
  logic [IN_W-1:0]   w_in;
  logic [IN_W-1:0]   r_s1;
  logic [IN_W-1:0]   r_s2;
  logic              r_s3_ck;
  logic              r_s3_st;

  rx_state_e         r_state;
  logic [ROW_AW-1:0] r_row;
  logic [COL_AW-1:0] r_col;
  logic [PWM_BITS-1:0] r_sub;
  logic              r_aligned;
  logic [CNT_W-1:0]  r_col_cnt;
  logic              r_wbuf;
  logic              r_done_pend;
  logic [LINE_W-1:0] r_line [2][COLS];

  logic              w_ck_rise;
  logic              w_st_rise;
  logic              w_busy;
  logic              w_latch;
  logic [LINE_W-1:0] w_bits;
  logic [ROW_AW-1:0] w_row_new;
  logic              w_wbuf_eff;
  logic [CNT_W-1:0]  w_col_eff;
  logic [LINE_W-1:0] w_line_rd;
  logic              w_acc_we;
  logic [ADDR_W-1:0] w_acc_addr;
  logic [ACC_W-1:0]  w_acc_rd;
  logic [ACC_W-1:0]  w_acc_new;

  assign w_in = {hub_R1, hub_G1, hub_B1, hub_R2, hub_G2, hub_B2,
                 hub_E, hub_D, hub_C, hub_B, hub_A, hub_CK, hub_ST, hub_OE};

  assign w_ck_rise  = r_s2[2] & ~r_s3_ck;
  assign w_st_rise  = r_s2[1] & ~r_s3_st;
  assign w_bits     = r_s2[13:8];
  assign w_row_new  = ROW_AW'(r_s2[7:3]);
  assign w_busy     = (r_state != IDLE);
  assign w_latch    = w_st_rise & ~w_busy;

  // A same-cycle ST is handled first, so the CK bit lands in column 0 of the new buffer
  assign w_wbuf_eff = w_latch ? ~r_wbuf : r_wbuf;
  assign w_col_eff  = w_st_rise ? '0 : r_col_cnt;

  // The pass always reads the buffer that is not being shifted into
  assign w_line_rd  = r_line[~r_wbuf][r_col];
  assign w_acc_we   = (r_state == WR);
  assign w_acc_addr = {r_row, r_col};

  hub75e_acc_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (ACC_W)
  ) u_acc_ram (
    .CLK_IN  (CLK_IN),
    .i_we    (w_acc_we),
    .i_waddr (w_acc_addr),
    .i_wdata (w_acc_new),
    .i_raddr (w_acc_addr),
    .o_rdata (w_acc_rd)
  );

  // Per-channel update: clear-and-load on subframe 0, saturating add otherwise
  always_comb begin
    w_acc_new = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (r_sub == '0) w_acc_new[i*CH_W +: CH_W] = CH_W'(w_line_rd[i]);
      else             w_acc_new[i*CH_W +: CH_W] = sat_inc(w_acc_rd[i*CH_W +: CH_W], w_line_rd[i]);
    end
  end

  // Shift path into the active line buffer
  always_ff @(posedge CLK_IN) begin
    if (resetn && w_ck_rise && (w_col_eff < CNT_W'(COLS)))
      r_line[w_wbuf_eff][w_col_eff[COL_AW-1:0]] <= w_bits;
  end

  // Synchronisers, latch handling and accumulate FSM
  always_ff @(posedge CLK_IN) begin
    if (!resetn) begin
      r_s1        <= '0;
      r_s2        <= '0;
      r_s3_ck     <= 1'b0;
      r_s3_st     <= 1'b0;
      r_state     <= IDLE;
      r_row       <= '0;
      r_col       <= '0;
      r_sub       <= '0;
      r_aligned   <= 1'b0;
      r_col_cnt   <= '0;
      r_wbuf      <= 1'b0;
      r_done_pend <= 1'b0;
      fb_we       <= 1'b0;
      fb_waddr    <= '0;
      fb_wdata    <= '0;
      frame_done  <= 1'b0;
      err_len     <= 1'b0;
      err_ovr     <= 1'b0;
      oe_bad      <= 1'b0;
    end else begin
      r_s1        <= w_in;
      r_s2        <= r_s1;
      r_s3_ck     <= r_s2[2];
      r_s3_st     <= r_s2[1];
      fb_we       <= 1'b0;
      frame_done  <= r_done_pend;
      r_done_pend <= 1'b0;

      if (w_ck_rise) begin
        r_col_cnt <= (w_col_eff >= CNT_W'(COLS)) ? w_col_eff : w_col_eff + CNT_W'(1);
        if (!r_s2[0]) oe_bad <= 1'b1;
      end else if (w_st_rise) begin
        r_col_cnt <= '0;
      end

      if (w_st_rise) begin
        if (r_col_cnt != CNT_W'(COLS)) err_len <= 1'b1;
        if (w_busy) begin
          // Previous line still accumulating: drop this one, keep row/sub/buffer
          err_ovr <= 1'b1;
        end else begin
          r_wbuf <= ~r_wbuf;
          r_row  <= w_row_new;
          if (!r_aligned) begin
            if (w_row_new == '0) begin
              r_aligned <= 1'b1;
              r_sub     <= '0;
              r_col     <= '0;
              r_state   <= RD;
            end
          end else begin
            if (w_row_new < r_row) r_sub <= r_sub + PWM_BITS'(1);
            r_col   <= '0;
            r_state <= RD;
          end
        end
      end

      case (r_state)
        RD: r_state <= WR;
        WR: begin
          if (r_sub == '1) begin
            fb_we    <= 1'b1;
            fb_waddr <= {r_row, r_col};
            fb_wdata <= pack_fb(rgb15_t'(w_acc_new[ACC_W-1:ACC_W/2]),
                                rgb15_t'(w_acc_new[ACC_W/2-1:0]));
            if ((r_row == '1) && (r_col == '1)) r_done_pend <= 1'b1;
          end
          if (r_col == '1) begin
            r_state <= IDLE;
          end else begin
            r_col   <= r_col + COL_AW'(1);
            r_state <= RD;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hub75e_rx.sv
// Directed bench for hub75e_rx on a reduced 4-row x 8-column geometry.
module tb_hub75e_rx;

  localparam int RB   = 2;
  localparam int CB   = 3;
  localparam int ROWS = 4;
  localparam int COLS = 8;
  localparam int PIX  = ROWS * COLS;
  localparam int SUBS = 32;
  localparam int AW   = RB + CB;

  logic CLK_IN = 1'b0;
  logic resetn;
  logic hub_R1, hub_G1, hub_B1, hub_R2, hub_G2, hub_B2;
  logic hub_A, hub_B, hub_C, hub_D, hub_E;
  logic hub_CK, hub_ST, hub_OE;
  logic          fb_we;
  logic [AW-1:0] fb_waddr;
  logic [31:0]   fb_wdata;
  logic          frame_done, err_len, err_ovr, oe_bad;

  int n_checks = 0;
  int n_errors = 0;
  int wr_count = 0;
  int fd_count = 0;
  logic [31:0] cap   [PIX];
  int          cap_n [PIX];

  int inj_short_sub = -1, inj_short_row = -1;
  int inj_oe_sub    = -1, inj_oe_row    = -1;
  int inj_ovr_sub   = -1, inj_ovr_row   = -1;
  int inj_rst_sub   = -1, inj_rst_row   = -1;
  int pre_last, wr_at_rst, fd_at_rst;
  int wb, fb;

  hub75e_rx #(.ROW_AW(RB), .COL_AW(CB)) dut (
    .CLK_IN(CLK_IN), .resetn(resetn),
    .hub_R1(hub_R1), .hub_G1(hub_G1), .hub_B1(hub_B1),
    .hub_R2(hub_R2), .hub_G2(hub_G2), .hub_B2(hub_B2),
    .hub_A(hub_A), .hub_B(hub_B), .hub_C(hub_C), .hub_D(hub_D), .hub_E(hub_E),
    .hub_CK(hub_CK), .hub_ST(hub_ST), .hub_OE(hub_OE),
    .fb_we(fb_we), .fb_waddr(fb_waddr), .fb_wdata(fb_wdata),
    .frame_done(frame_done), .err_len(err_len), .err_ovr(err_ovr), .oe_bad(oe_bad)
  );

  always #5 CLK_IN = ~CLK_IN;

  // Capture frame-RAM writes and end-of-image pulses
  always @(negedge CLK_IN) begin
    if (fb_we === 1'b1) begin
      cap[fb_waddr]   <= fb_wdata;
      cap_n[fb_waddr] <= wr_count + 1;
      wr_count        <= wr_count + 1;
    end
    if (frame_done === 1'b1) fd_count <= fd_count + 1;
  end

  task automatic tick();
    @(posedge CLK_IN);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_checks++;
    assert (obs === want) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  // Pixel value per mode: 0 solid (31,0,16), 1 gradient, 2 second solid colour
  function automatic logic [4:0] pix(input int mode, input int r, input int c,
                                     input int half, input int ch);
    int v;
    case (mode)
      0: v = (ch == 0) ? 31 : (ch == 1) ? 0 : 16;
      1: begin
        v = (r * COLS + c) % 32;
        if (half != 0) v = 31 - v;
      end
      default: begin
        if (half != 0) v = (ch == 0) ? 0 : (ch == 1) ? 31 : 9;
        else           v = (ch == 0) ? 5 : (ch == 1) ? 27 : 1;
      end
    endcase
    return 5'(v);
  endfunction

  function automatic logic [31:0] exp_word(input int mode, input int r, input int c);
    return {1'b0, pix(mode, r, c, 0, 0), pix(mode, r, c, 0, 1), pix(mode, r, c, 0, 2),
            1'b0, pix(mode, r, c, 1, 0), pix(mode, r, c, 1, 1), pix(mode, r, c, 1, 2)};
  endfunction

  task automatic do_reset();
    resetn = 1'b0;
    tick();
    chk("rst_mid_fb_we", 32'(fb_we), 32'd0);
    chk("rst_mid_frame_done", 32'(frame_done), 32'd0);
    chk("rst_mid_err_len", 32'(err_len), 32'd0);
    chk("rst_mid_err_ovr", 32'(err_ovr), 32'd0);
    chk("rst_mid_oe_bad", 32'(oe_bad), 32'd0);
    chk("rst_mid_waddr", 32'(fb_waddr), 32'd0);
    chk("rst_mid_wdata", fb_wdata, 32'd0);
    tick();
    resetn    = 1'b1;
    wr_at_rst = wr_count;
    fd_at_rst = fd_count;
  endtask

  // One scan line: shift columns (CK 2 low / 2 high), then address and ST
  task automatic send_line(input int mode, input int row, input int sub);
    int ncols;
    ncols  = (sub == inj_short_sub && row == inj_short_row) ? COLS - 1 : COLS;
    hub_OE = !(sub == inj_oe_sub && row == inj_oe_row);
    for (int c = 0; c < ncols; c++) begin
      hub_CK = 1'b0;
      hub_R1 = int'(pix(mode, row, c, 0, 0)) > sub;
      hub_G1 = int'(pix(mode, row, c, 0, 1)) > sub;
      hub_B1 = int'(pix(mode, row, c, 0, 2)) > sub;
      hub_R2 = int'(pix(mode, row, c, 1, 0)) > sub;
      hub_G2 = int'(pix(mode, row, c, 1, 1)) > sub;
      hub_B2 = int'(pix(mode, row, c, 1, 2)) > sub;
      if (sub == inj_rst_sub && row == inj_rst_row && c == 2) do_reset();
      tick(); tick();
      hub_CK = 1'b1;
      tick(); tick();
    end
    hub_CK = 1'b0;
    {hub_E, hub_D, hub_C, hub_B, hub_A} = 5'(row);
    tick();
    hub_ST = 1'b1;
    tick(); tick();
    hub_ST = 1'b0;
    hub_OE = 1'b0;
    if (sub == inj_ovr_sub && row == inj_ovr_row) begin
      repeat (6) tick();
      hub_ST = 1'b1;
      tick(); tick();
      hub_ST = 1'b0;
    end
  endtask

  task automatic send_image(input int mode);
    for (int s = 0; s < SUBS; s++) begin
      if (s == SUBS - 1) pre_last = wr_count;
      for (int r = 0; r < ROWS; r++) send_line(mode, r, s);
    end
  endtask

  task automatic check_image(input int mode, input int wbase, input int fbase);
    chk("image_write_count", 32'(wr_count - wbase), 32'(PIX));
    chk("image_frame_done_count", 32'(fd_count - fbase), 32'd1);
    for (int a = 0; a < PIX; a++) begin
      chk($sformatf("fb_word[%0d]", a), cap[a], exp_word(mode, a / COLS, a % COLS));
      chk($sformatf("fb_fresh[%0d]", a), 32'(cap_n[a] > wbase), 32'd1);
    end
  endtask

  initial begin
    resetn = 1'b0;
    {hub_R1, hub_G1, hub_B1, hub_R2, hub_G2, hub_B2} = '0;
    {hub_E, hub_D, hub_C, hub_B, hub_A} = '0;
    hub_CK = 1'b0;
    hub_ST = 1'b0;
    hub_OE = 1'b1;
    repeat (3) tick();
    chk("reset_fb_we", 32'(fb_we), 32'd0);
    chk("reset_frame_done", 32'(frame_done), 32'd0);
    chk("reset_err_len", 32'(err_len), 32'd0);
    chk("reset_err_ovr", 32'(err_ovr), 32'd0);
    chk("reset_oe_bad", 32'(oe_bad), 32'd0);
    chk("reset_waddr", 32'(fb_waddr), 32'd0);
    chk("reset_wdata", fb_wdata, 32'd0);
    resetn = 1'b1;
    repeat (2) tick();

    // Mid-image start, then a solid-colour image
    send_line(0, 2, 0);
    send_line(0, 3, 0);
    repeat (20) tick();
    chk("unaligned_writes", 32'(wr_count), 32'd0);
    wb = wr_count;
    fb = fd_count;
    send_image(0);
    chk("writes_before_last_sub", 32'(pre_last - wb), 32'd0);
    repeat (40) tick();
    check_image(0, wb, fb);
    chk("solid_word_first", cap[0], 32'h7C10_7C10);
    chk("solid_word_last", cap[PIX-1], 32'h7C10_7C10);
    chk("solid_err_len", 32'(err_len), 32'd0);
    chk("solid_err_ovr", 32'(err_ovr), 32'd0);
    chk("solid_oe_bad", 32'(oe_bad), 32'd0);

    // Short line and OE-low shifting inside an image
    inj_short_sub = 10; inj_short_row = 1;
    inj_oe_sub    = 12; inj_oe_row    = 2;
    fb = fd_count;
    send_image(2);
    repeat (40) tick();
    chk("short_err_len", 32'(err_len), 32'd1);
    chk("short_oe_bad", 32'(oe_bad), 32'd1);
    chk("short_err_ovr", 32'(err_ovr), 32'd0);
    chk("short_frame_done", 32'(fd_count - fb), 32'd1);
    inj_short_sub = -1;
    inj_oe_sub    = -1;

    // Gradient image with an overrun strobe
    inj_ovr_sub = 5; inj_ovr_row = 1;
    wb = wr_count;
    fb = fd_count;
    send_image(1);
    repeat (40) tick();
    inj_ovr_sub = -1;
    chk("ovr_err_ovr", 32'(err_ovr), 32'd1);
    chk("ovr_err_len_sticky", 32'(err_len), 32'd1);
    check_image(1, wb, fb);
    chk("grad_word_r1c1", cap[9], 32'h2529_5AD6);
    chk("grad_word_r0c0", cap[0], 32'h0000_7FFF);

    // Reset in the middle of a last-subframe pass
    inj_rst_sub = 31; inj_rst_row = 2;
    send_image(0);
    repeat (40) tick();
    inj_rst_sub = -1;
    chk("post_reset_writes", 32'(wr_count - wr_at_rst), 32'd0);
    chk("post_reset_frame_done", 32'(fd_count - fd_at_rst), 32'd0);

    // Re-alignment on the next row-0 latch
    wb = wr_count;
    fb = fd_count;
    send_image(2);
    repeat (40) tick();
    check_image(2, wb, fb);
    chk("realign_word0", cap[0], 32'h1761_03E9);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
